// File: rtl/cache_controller.sv
// Direct-mapped 8-line write-through cache controller with registered CPU and memory sides.
// Latency: read hit 2 cycles handshake-to-cpu_done, miss/write k+2; one request in flight, cpu_ready only in IDLE.
module cache_controller #(
    parameter int MEM_LAT_MAX = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_valid,
    input  logic       RWB,
    input  logic [5:0] Address,
    input  logic [7:0] Data,
    input  logic       flush,
    output logic       cpu_ready,
    output logic       cpu_done,
    output logic       cpu_hit,
    output logic [7:0] rdata,
    output logic       mem_req,
    output logic       mem_we,
    output logic [5:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    output logic       mem_err,
    output logic [7:0] hit_count,
    output logic [7:0] miss_count
);
    localparam int CW = $clog2(MEM_LAT_MAX + 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WMEM, DONE} state_t;

    state_t        state;
    logic [7:0]    line_vld;
    logic [2:0]    line_tag [8];
    logic [7:0]    line_dat [8];
    logic          req_rwb;
    logic [5:0]    req_addr;
    logic [7:0]    req_data;
    logic [CW-1:0] wait_cnt;

    logic [2:0]    idx;
    logic [2:0]    tag;
    logic          hit;
    logic          timeout;
    logic          dat_we;
    logic          tag_we;
    logic [7:0]    dat_wdat;

    always_comb begin
        idx       = req_addr[2:0];
        tag       = req_addr[5:3];
        hit       = line_vld[idx] && (line_tag[idx] == tag);
        timeout   = (wait_cnt == CW'(MEM_LAT_MAX - 1));
        cpu_ready = (state == IDLE) && !flush;
        // Reset forces state to IDLE, so an aborted fill can never reach the array.
        tag_we    = (state == FILL) && mem_ack;
        dat_we    = tag_we || ((state == LOOKUP) && !req_rwb && hit);
        dat_wdat  = (state == FILL) ? mem_rdata : req_data;
    end

    always_ff @(posedge clk) begin
        if (dat_we)
            line_dat[idx] <= dat_wdat;
        if (tag_we)
            line_tag[idx] <= tag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            line_vld   <= '0;
            req_rwb    <= 1'b0;
            req_addr   <= '0;
            req_data   <= '0;
            wait_cnt   <= '0;
            cpu_done   <= 1'b0;
            cpu_hit    <= 1'b0;
            rdata      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_err    <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            cpu_done <= 1'b0;
            mem_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        line_vld <= '0;
                    end else if (cpu_valid) begin
                        req_rwb  <= RWB;
                        req_addr <= Address;
                        req_data <= Data;
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    wait_cnt <= '0;
                    cpu_hit  <= hit;
                    if (hit) begin
                        if (hit_count != 8'hFF)
                            hit_count <= hit_count + 8'd1;
                    end else if (miss_count != 8'hFF) begin
                        miss_count <= miss_count + 8'd1;
                    end
                    if (req_rwb && hit) begin
                        rdata <= line_dat[idx];
                        state <= DONE;
                    end else if (req_rwb) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= req_addr;
                        state    <= FILL;
                    end else begin
                        // Write-through without allocate: memory is always written.
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= req_addr;
                        mem_wdata <= req_data;
                        state     <= WMEM;
                    end
                end
                FILL, WMEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (state == FILL) begin
                            line_vld[idx] <= 1'b1;
                            rdata         <= mem_rdata;
                        end
                        state <= DONE;
                    end else if (timeout) begin
                        mem_req <= 1'b0;
                        mem_err <= 1'b1;
                        state   <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                DONE: begin
                    cpu_done <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: hand-computed hits, misses, latencies, flush, timeout and reset abort.
module tb_cache_controller;
    localparam int LAT = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpu_valid;
    logic       RWB;
    logic [5:0] Address;
    logic [7:0] Data;
    logic       flush;
    logic       cpu_ready;
    logic       cpu_done;
    logic       cpu_hit;
    logic [7:0] rdata;
    logic       mem_req;
    logic       mem_we;
    logic [5:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic       mem_err;
    logic [7:0] hit_count;
    logic [7:0] miss_count;

    int total = 0;
    int bad   = 0;

    cache_controller #(.MEM_LAT_MAX(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_valid(cpu_valid), .RWB(RWB),
        .Address(Address), .Data(Data), .flush(flush), .cpu_ready(cpu_ready),
        .cpu_done(cpu_done), .cpu_hit(cpu_hit), .rdata(rdata), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // One CPU access; acks memory ack_k cycles after mem_req rises (0 = never).
    task automatic access(input logic rwb, input logic [5:0] addr, input logic [7:0] wd,
                          input int ack_k, input logic [7:0] mrd,
                          output logic rdy, output int lat, output logic hit,
                          output logic [7:0] rd, output int req_cycles, output int err_cnt,
                          output logic mem_bad, output logic done_after);
        @(negedge clk);
        RWB = rwb; Address = addr; Data = wd; cpu_valid = 1'b1;
        rdy = cpu_ready;
        @(negedge clk);
        cpu_valid = 1'b0; Address = ~addr; Data = ~wd; RWB = ~rwb;
        lat = 0; req_cycles = 0; err_cnt = 0; mem_bad = 1'b0;
        while (!cpu_done && lat < 400) begin
            @(negedge clk);
            lat++;
            mem_ack = 1'b0;
            if (mem_err) err_cnt++;
            if (mem_req) begin
                req_cycles++;
                if (mem_addr !== addr || mem_we !== !rwb || (!rwb && mem_wdata !== wd))
                    mem_bad = 1'b1;
                if (ack_k > 0 && req_cycles == ack_k) begin
                    mem_ack = 1'b1; mem_rdata = mrd;
                end
            end
        end
        hit = cpu_hit; rd = rdata;
        @(negedge clk);
        done_after = cpu_done;
    endtask

    logic r_rdy, r_hit, r_bad, r_done2;
    logic [7:0] r_rd;
    int r_lat, r_req, r_err;

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        total++; if (cpu_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cpu_ready); end
        total++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_err !== 1'b0) begin bad++; $display("FAIL reset_mem got=%b%b%b want=000", mem_req, mem_we, mem_err); end
        total++; if (cpu_done !== 1'b0 || cpu_hit !== 1'b0) begin bad++; $display("FAIL reset_cpu got=%b%b want=00", cpu_done, cpu_hit); end
        total++; if (rdata !== 8'h00 || mem_addr !== 6'h00 || mem_wdata !== 8'h00) begin bad++; $display("FAIL reset_data got=%h/%h/%h want=0", rdata, mem_addr, mem_wdata); end
        total++; if (hit_count !== 8'h00 || miss_count !== 8'h00) begin bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", hit_count, miss_count); end
        rst_n = 1'b1;
    endtask

    task automatic test_cold_read();
        access(1'b1, 6'h2A, 8'h00, 3, 8'h5C, r_rdy, r_lat, r_hit, r_rd, r_req, r_err, r_bad, r_done2);
        total++; if (r_rdy !== 1'b1) begin bad++; $display("FAIL cold_ready got=%b want=1", r_rdy); end
        total++; if (r_hit !== 1'b0 || r_rd !== 8'h5C) begin bad++; $display("FAIL cold_result got hit=%b rd=%h want hit=0 rd=5c", r_hit, r_rd); end
        total++; if (r_lat !== 5) begin bad++; $display("FAIL cold_latency got=%0d want=5", r_lat); end
        total++; if (r_bad !== 1'b0 || r_req !== 3) begin bad++; $display("FAIL cold_mem got bad=%b req=%0d want bad=0 req=3", r_bad, r_req); end
        total++; if (r_done2 !== 1'b0) begin bad++; $display("FAIL cold_done_width got=%b want=0", r_done2); end
        total++; if (miss_count !== 8'd1 || hit_count !== 8'd0) begin bad++; $display("FAIL cold_cnt got=%0d/%0d want=0/1", hit_count, miss_count); end
    endtask

    task automatic test_reread();
        access(1'b1, 6'h2A, 8'h00, 3, 8'hEE, r_rdy, r_lat, r_hit, r_rd, r_req, r_err, r_bad, r_done2);
        total++; if (r_hit !== 1'b1 || r_rd !== 8'h5C) begin bad++; $display("FAIL reread_result got hit=%b rd=%h want hit=1 rd=5c", r_hit, r_rd); end
        total++; if (r_lat !== 2) begin bad++; $display("FAIL reread_latency got=%0d want=2", r_lat); end
        total++; if (r_req !== 0) begin bad++; $display("FAIL reread_memreq got=%0d want=0", r_req); end
        total++; if (hit_count !== 8'd1) begin bad++; $display("FAIL reread_hits got=%0d want=1", hit_count); end
    endtask

    task automatic test_write_hit_conflict();
        access(1'b0, 6'h2A, 8'h81, 2, 8'h00, r_rdy, r_lat, r_hit, r_rd, r_req, r_err, r_bad, r_done2);
        total++; if (r_hit !== 1'b1 || r_lat !== 4) begin bad++; $display("FAIL wr_hit got hit=%b lat=%0d want hit=1 lat=4", r_hit, r_lat); end
        total++; if (r_bad !== 1'b0 || r_req !== 2) begin bad++; $display("FAIL wr_hit_mem got bad=%b req=%0d want bad=0 req=2", r_bad, r_req); end
        total++; if (r_rd !== 8'h5C) begin bad++; $display("FAIL wr_rdata_hold got=%h want=5c", r_rd); end
        access(1'b1, 6'h2A, 8'h00, 1, 8'hEE, r_rdy, r_lat, r_hit, r_rd, r_req, r_err, r_bad, r_done2);
        total++; if (r_hit !== 1'b1 || r_rd !== 8'h81) begin bad++; $display("FAIL wr_readback got hit=%b rd=%h want hit=1 rd=81", r_hit, r_rd); end
        access(1'b1, 6'h12, 8'h00, 1, 8'h3C, r_rdy, r_lat, r_hit, r_rd, r_req, r_err, r_bad, r_done2);
        total++; if (r_hit !== 1'b0 || r_rd !== 8'h3C || r_lat !== 3) begin bad++; $display("FAIL conflict_miss got hit=%b rd=%h lat=%0d want hit=0 rd=3c lat=3", r_hit, r_rd, r_lat); end
        access(1'b1, 6'h12, 8'h00, 1, 8'hEE, r_rdy, r_lat, r_hit, r_rd, r_req, r_err, r_bad, r_done2);
        total++; if (r_hit !== 1'b1 || r_rd !== 8'h3C) begin bad++; $display("FAIL conflict_tag2 got hit=%b rd=%h want hit=1 rd=3c", r_hit, r_rd); end
        access(1'b1, 6'h2A, 8'h00, 1, 8'h11, r_rdy, r_lat, r_hit, r_rd, r_req, r_err, r_bad, r_done2);
        total++; if (r_hit !== 1'b0 || r_rd !== 8'h11) begin bad++; $display("FAIL evicted got hit=%b rd=%h want hit=0 rd=11", r_hit, r_rd); end
        total++; if (hit_count !== 8'd4 || miss_count !== 8'd3) begin bad++; $display("FAIL conflict_cnt got=%0d/%0d want=4/3", hit_count, miss_count); end
    endtask

    task automatic test_write_miss();
        access(1'b0, 6'h07, 8'hFF, 2, 8'h00, r_rdy, r_lat, r_hit, r_rd, r_req, r_err, r_bad, r_done2);
        total++; if (r_hit !== 1'b0 || r_bad !== 1'b0 || r_req !== 2) begin bad++; $display("FAIL wmiss got hit=%b bad=%b req=%0d want hit=0 bad=0 req=2", r_hit, r_bad, r_req); end
        access(1'b1, 6'h07, 8'h00, 2, 8'h44, r_rdy, r_lat, r_hit, r_rd, r_req, r_err, r_bad, r_done2);
        total++; if (r_hit !== 1'b0 || r_rd !== 8'h44 || r_lat !== 4) begin bad++; $display("FAIL wmiss_noalloc got hit=%b rd=%h lat=%0d want hit=0 rd=44 lat=4", r_hit, r_rd, r_lat); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] done_bits;
        logic       rdy_at2;
        @(negedge clk);
        RWB = 1'b1; Address = 6'h2A; cpu_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            done_bits[i] = cpu_done;
            if (i == 2) rdy_at2 = cpu_ready;
        end
        cpu_valid = 1'b0;
        total++; if (done_bits !== 6'b100100) begin bad++; $display("FAIL b2b_done got=%b want=100100", done_bits); end
        total++; if (rdy_at2 !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", rdy_at2); end
        total++; if (hit_count !== 8'd6 || rdata !== 8'h11) begin bad++; $display("FAIL b2b_cnt got=%0d rd=%h want=6 rd=11", hit_count, rdata); end
    endtask

    task automatic test_flush();
        logic seen;
        @(negedge clk);
        flush = 1'b1; cpu_valid = 1'b1; RWB = 1'b1; Address = 6'h2A;
        #1;
        total++; if (cpu_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", cpu_ready); end
        @(negedge clk);
        flush = 1'b0; cpu_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (cpu_done || mem_req || !cpu_ready) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_ignored got=%b want=0", seen); end
        access(1'b1, 6'h2A, 8'h00, 1, 8'h66, r_rdy, r_lat, r_hit, r_rd, r_req, r_err, r_bad, r_done2);
        total++; if (r_hit !== 1'b0 || r_rd !== 8'h66) begin bad++; $display("FAIL flush_miss got hit=%b rd=%h want hit=0 rd=66", r_hit, r_rd); end
    endtask

    task automatic test_timeout();
        access(1'b1, 6'h33, 8'h00, 0, 8'h99, r_rdy, r_lat, r_hit, r_rd, r_req, r_err, r_bad, r_done2);
        total++; if (r_err !== 1 || r_req !== LAT) begin bad++; $display("FAIL timeout_err got err=%0d req=%0d want err=1 req=%0d", r_err, r_req, LAT); end
        total++; if (r_lat !== LAT + 2) begin bad++; $display("FAIL timeout_latency got=%0d want=%0d", r_lat, LAT + 2); end
        total++; if (r_rd !== 8'h66 || r_hit !== 1'b0) begin bad++; $display("FAIL timeout_rdata got rd=%h hit=%b want rd=66 hit=0", r_rd, r_hit); end
        access(1'b1, 6'h33, 8'h00, 1, 8'h77, r_rdy, r_lat, r_hit, r_rd, r_req, r_err, r_bad, r_done2);
        total++; if (r_hit !== 1'b0 || r_rd !== 8'h77 || r_err !== 0) begin bad++; $display("FAIL timeout_noline got hit=%b rd=%h err=%0d want hit=0 rd=77 err=0", r_hit, r_rd, r_err); end
        total++; if (miss_count !== 8'd8) begin bad++; $display("FAIL timeout_cnt got=%0d want=8", miss_count); end
    endtask

    task automatic test_reset_in_fill();
        int  wait_n;
        logic seen;
        @(negedge clk);
        RWB = 1'b1; Address = 6'h15; cpu_valid = 1'b1;
        @(negedge clk);
        cpu_valid = 1'b0;
        wait_n = 0;
        while (!mem_req && wait_n < 10) begin @(negedge clk); wait_n++; end
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rstfill_req got=%b want=1", mem_req); end
        rst_n = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rstfill_drop got=%b want=0", mem_req); end
        total++; if (hit_count !== 8'd0 || miss_count !== 8'd0) begin bad++; $display("FAIL rstfill_cnt got=%0d/%0d want=0/0", hit_count, miss_count); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            mem_ack = (i == 2); mem_rdata = 8'hAB;
            @(negedge clk);
            if (cpu_done || mem_req || mem_err) seen = 1'b1;
        end
        mem_ack = 1'b0;
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstfill_quiet got=%b want=0", seen); end
        access(1'b1, 6'h15, 8'h00, 1, 8'h5A, r_rdy, r_lat, r_hit, r_rd, r_req, r_err, r_bad, r_done2);
        total++; if (r_hit !== 1'b0 || r_rd !== 8'h5A || miss_count !== 8'd1) begin bad++; $display("FAIL rstfill_noline got hit=%b rd=%h miss=%0d want hit=0 rd=5a miss=1", r_hit, r_rd, miss_count); end
    endtask

    initial begin
        rst_n = 1'b0; cpu_valid = 1'b0; RWB = 1'b0; Address = '0; Data = '0;
        flush = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
        test_reset();
        test_cold_read();
        test_reread();
        test_write_hit_conflict();
        test_write_miss();
        test_back_to_back();
        test_flush();
        test_timeout();
        test_reset_in_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
